pe_task_sequencer: RTL and testbench

Per-processor task sequencer sitting directly downstream of the coprocessor main control unit, one instance per processor. It accepts a block (row, column) assignment through the one-hot index-ready handshake and computes the memory addresses of every operand block of that assignment. It streams those addresses to the processor datapath, then signals result-ready so the control unit can scatter the next round. Unassigned or out-of-range slots complete immediately without issuing addresses.

---
 rtl/pe_task_sequencer_pkg.sv | 35 +++
 rtl/pe_task_sequencer_if.sv | 14 +
 rtl/pe_task_sequencer_tile_addr.sv | 72 +++++++
 rtl/pe_task_sequencer.sv | 186 ++++++++++++++++++
 tb/tb_pe_task_sequencer.sv | 240 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pe_task_sequencer_pkg.sv
// Shared types for the per-processor task sequencer.
// Latency: n/a (types, constants and a helper only).
// Backpressure: n/a.
package pe_task_sequencer_pkg;

   // Sequencer FSM states
   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_ACK     = 3'd1,
      ST_FETCH_A = 3'd2,
      ST_FETCH_B = 3'd3,
      ST_WAIT_PE = 3'd4,
      ST_WRITE_C = 3'd5,
      ST_DONE    = 3'd6
   } state_e;

   // Address kind presented alongside every datapath address
   typedef enum logic [1:0] {
      KIND_A = 2'b00,
      KIND_B = 2'b01,
      KIND_C = 2'b10
   } addr_kind_e;

   // Config word field positions and width
   localparam int LAMBDA_LSB  = 0;
   localparam int GAMMA_LSB   = 8;
   localparam int MU_LSB      = 16;
   localparam int CFG_FIELD_W = 8;

   // States in which an address is being presented to the datapath
   function automatic logic is_addr_state(input state_e s);
      return (s == ST_FETCH_A) || (s == ST_FETCH_B) || (s == ST_WRITE_C);
   endfunction

endpackage

// File: rtl/pe_task_sequencer_if.sv
// Address stream from the sequencer to the processor datapath.
// Latency: n/a (signal bundle).
// Backpressure: valid/ready; transfer when both high at a rising edge.
interface pe_task_sequencer_if #(
   parameter int ADDR_W = 10
) ();
   logic              Addr_Valid;
   logic [ADDR_W-1:0] Addr;
   logic [1:0]        Addr_Kind;
   logic              Addr_Ready;

   modport master (output Addr_Valid, output Addr, output Addr_Kind, input Addr_Ready);
   modport slave  (input Addr_Valid, input Addr, input Addr_Kind, output Addr_Ready);
endinterface

// File: rtl/pe_task_sequencer_tile_addr.sv
// Block address generator: base + (x*y + z)*BLOCK_WORDS + w for A, B or C blocks.
// Latency: 1 cycle, address registered when i_Load is high.
// Backpressure: holds its output while i_Load is low; caller re-presents the same operands on a stall.
module tile_addr_gen
   import pe_task_sequencer_pkg::*;
#(
   parameter int index_width     = 8,
   parameter int memory_size_log = 10,
   parameter int BLOCK_WORDS     = 4,
   parameter int W_BITS          = 2,
   parameter int A_BASE          = 0,
   parameter int B_BASE          = 256,
   parameter int C_BASE          = 512
) (
   input  logic                       i_Clock,
   input  logic                       i_Reset,
   input  logic                       i_Load,
   input  addr_kind_e                 i_Kind,
   input  logic [index_width-1:0]     i_Row,
   input  logic [index_width-1:0]     i_Col,
   input  logic [index_width-1:0]     i_K,
   input  logic [index_width-1:0]     i_Mu,
   input  logic [index_width-1:0]     i_Gamma,
   input  logic [W_BITS-1:0]          i_W,
   output logic [memory_size_log-1:0] o_Addr,
   output addr_kind_e                 o_Kind
);
   logic [index_width-1:0]     w_Op_X;
   logic [index_width-1:0]     w_Op_Y;
   logic [index_width-1:0]     w_Op_Z;
   logic [memory_size_log-1:0] w_Base;
   logic [2*index_width-1:0]   w_Block;
   logic [memory_size_log-1:0] w_Next_Addr;

   // Pick the row/col/k operands for the block kind, then form the word address modulo 2^memory_size_log
   always_comb begin
      w_Op_X = i_Row;
      w_Op_Y = i_Mu;
      w_Op_Z = i_K;
      w_Base = memory_size_log'(A_BASE);
      case (i_Kind)
         KIND_B: begin
            w_Op_X = i_K;
            w_Op_Y = i_Gamma;
            w_Op_Z = i_Col;
            w_Base = memory_size_log'(B_BASE);
         end
         KIND_C: begin
            w_Op_X = i_Row;
            w_Op_Y = i_Gamma;
            w_Op_Z = i_Col;
            w_Base = memory_size_log'(C_BASE);
         end
         default: ;
      endcase
      w_Block     = {{index_width{1'b0}}, w_Op_X} * {{index_width{1'b0}}, w_Op_Y}
                  + {{index_width{1'b0}}, w_Op_Z};
      w_Next_Addr = memory_size_log'(w_Block) * memory_size_log'(BLOCK_WORDS)
                  + memory_size_log'(i_W) + w_Base;
   end

   // Output register: captures the address the sequencer will present next cycle
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         o_Addr <= '0;
         o_Kind <= KIND_A;
      end else if (i_Load) begin
         o_Addr <= w_Next_Addr;
         o_Kind <= i_Kind;
      end
   end
endmodule

// File: rtl/pe_task_sequencer.sv
// Per-processor task sequencer: accepts a block (i,j) and streams A/B operand then C result addresses.
// Latency: ack one cycle after index-ready, first address two cycles after; one address per cycle thereafter.
// Backpressure: address held stable while valid and not ready; index-ready only honoured in IDLE/DONE.
module pe_task_sequencer
   import pe_task_sequencer_pkg::*;
#(
   parameter int index_width     = 8,
   parameter int memory_size_log = 10,
   parameter int BLOCK_WORDS     = 4,
   parameter int A_BASE          = 0,
   parameter int B_BASE          = 256,
   parameter int C_BASE          = 512
) (
   input  logic                   i_Clock,
   input  logic                   i_Reset,
   input  logic [31:0]            i_Config,
   input  logic [index_width-1:0] i_Row_Index,
   input  logic [index_width-1:0] i_Column_Index,
   input  logic                   i_Index_Ready,
   output logic                   o_Index_Received,
   input  logic                   i_Compute_Done,
   output logic                   o_Task_Done,
   pe_task_sequencer_if.master    addr_if
);
   // A zero-width word counter is illegal, so a single-word block still gets one bit
   localparam int W_BITS = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1;
   localparam logic [W_BITS-1:0] W_LAST = W_BITS'(BLOCK_WORDS - 1);

   state_e                     r_State;
   state_e                     w_Next_State;
   logic [index_width-1:0]     r_K;
   logic [index_width-1:0]     w_Next_K;
   logic [W_BITS-1:0]          r_W;
   logic [W_BITS-1:0]          w_Next_W;
   logic [index_width-1:0]     r_Row;
   logic [index_width-1:0]     r_Col;
   logic [index_width-1:0]     r_Lambda;
   logic [index_width-1:0]     r_Gamma;
   logic [index_width-1:0]     r_Mu;
   logic                       r_Addr_Valid;
   logic                       w_Accept;
   logic                       w_Load;
   addr_kind_e                 w_Next_Kind;
   addr_kind_e                 w_Kind;
   logic [memory_size_log-1:0] w_Addr;
   logic                       w_unused_cfg;

   assign w_unused_cfg = ^i_Config[31:MU_LSB+CFG_FIELD_W];
   assign w_Accept     = ((r_State == ST_IDLE) || (r_State == ST_DONE)) && i_Index_Ready;

   // Capture the task and its matrix geometry when a new assignment is taken
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_Row    <= '0;
         r_Col    <= '0;
         r_Lambda <= '0;
         r_Gamma  <= '0;
         r_Mu     <= '0;
      end else if (w_Accept) begin
         r_Row    <= i_Row_Index;
         r_Col    <= i_Column_Index;
         r_Lambda <= index_width'(i_Config[LAMBDA_LSB +: CFG_FIELD_W]);
         r_Gamma  <= index_width'(i_Config[GAMMA_LSB +: CFG_FIELD_W]);
         r_Mu     <= index_width'(i_Config[MU_LSB +: CFG_FIELD_W]);
      end
   end

   // Next state and next k/w; in address states a transfer is simply i_Addr_Ready since valid is implied
   always_comb begin
      w_Next_State = r_State;
      w_Next_K     = r_K;
      w_Next_W     = r_W;
      case (r_State)
         ST_IDLE, ST_DONE: begin
            if (i_Index_Ready) w_Next_State = ST_ACK;
         end
         ST_ACK: begin
            if ((r_Row >= r_Lambda) || (r_Col >= r_Gamma)) begin
               w_Next_State = ST_DONE;
            end else if (r_Mu == '0) begin
               w_Next_State = ST_WAIT_PE;
            end else begin
               w_Next_State = ST_FETCH_A;
               w_Next_K     = '0;
               w_Next_W     = '0;
            end
         end
         ST_FETCH_A: begin
            if (addr_if.Addr_Ready) begin
               if (r_W == W_LAST) begin
                  w_Next_W     = '0;
                  w_Next_State = ST_FETCH_B;
               end else begin
                  w_Next_W = r_W + W_BITS'(1);
               end
            end
         end
         ST_FETCH_B: begin
            if (addr_if.Addr_Ready) begin
               if (r_W == W_LAST) begin
                  w_Next_W = '0;
                  if (r_K == r_Mu - index_width'(1)) begin
                     w_Next_State = ST_WAIT_PE;
                  end else begin
                     w_Next_K     = r_K + index_width'(1);
                     w_Next_State = ST_FETCH_A;
                  end
               end else begin
                  w_Next_W = r_W + W_BITS'(1);
               end
            end
         end
         ST_WAIT_PE: begin
            if (i_Compute_Done) begin
               w_Next_W     = '0;
               w_Next_State = ST_WRITE_C;
            end
         end
         ST_WRITE_C: begin
            if (addr_if.Addr_Ready) begin
               if (r_W == W_LAST) begin
                  w_Next_W     = '0;
                  w_Next_State = ST_DONE;
               end else begin
                  w_Next_W = r_W + W_BITS'(1);
               end
            end
         end
         default: w_Next_State = ST_IDLE;
      endcase
   end

   // Address for the next cycle is computed from next-state values so outputs stay registered with no bubble
   always_comb begin
      w_Load      = is_addr_state(w_Next_State);
      w_Next_Kind = KIND_A;
      if (w_Next_State == ST_FETCH_B) w_Next_Kind = KIND_B;
      if (w_Next_State == ST_WRITE_C) w_Next_Kind = KIND_C;
   end

   // State, counters and registered status outputs
   always_ff @(posedge i_Clock or posedge i_Reset) begin
      if (i_Reset) begin
         r_State          <= ST_IDLE;
         r_K              <= '0;
         r_W              <= '0;
         r_Addr_Valid     <= 1'b0;
         o_Index_Received <= 1'b0;
         o_Task_Done      <= 1'b0;
      end else begin
         r_State          <= w_Next_State;
         r_K              <= w_Next_K;
         r_W              <= w_Next_W;
         r_Addr_Valid     <= w_Load;
         o_Index_Received <= (w_Next_State == ST_ACK);
         o_Task_Done      <= (w_Next_State == ST_DONE);
      end
   end

   tile_addr_gen #(
      .index_width    (index_width),
      .memory_size_log(memory_size_log),
      .BLOCK_WORDS    (BLOCK_WORDS),
      .W_BITS         (W_BITS),
      .A_BASE         (A_BASE),
      .B_BASE         (B_BASE),
      .C_BASE         (C_BASE)
   ) u_tile_addr_gen (
      .i_Clock(i_Clock),
      .i_Reset(i_Reset),
      .i_Load (w_Load),
      .i_Kind (w_Next_Kind),
      .i_Row  (r_Row),
      .i_Col  (r_Col),
      .i_K    (w_Next_K),
      .i_Mu   (r_Mu),
      .i_Gamma(r_Gamma),
      .i_W    (w_Next_W),
      .o_Addr (w_Addr),
      .o_Kind (w_Kind)
   );

   assign addr_if.Addr_Valid = r_Addr_Valid;
   assign addr_if.Addr       = w_Addr;
   assign addr_if.Addr_Kind  = w_Kind;
endmodule

// File: tb/tb_pe_task_sequencer.sv
// Directed bench: expected addresses queued by stimulus, compared by a negedge monitor on each transfer.
// Latency: n/a.
// Backpressure: address ready either held high or toggled every cycle.
module tb_pe_task_sequencer;
   import pe_task_sequencer_pkg::*;

   typedef struct {
      logic [9:0] a;
      logic [1:0] k;
   } exp_t;

   logic        clk;
   logic        rst;
   logic [31:0] cfg;
   logic [7:0]  row;
   logic [7:0]  col;
   logic        idx_rdy;
   logic        idx_rcv;
   logic        cdone;
   logic        tdone;
   logic        toggle;
   int          total;
   int          bad;
   exp_t        q[$];
   logic        stall_pend;
   logic [9:0]  stall_addr;
   logic [1:0]  stall_kind;

   pe_task_sequencer_if #(.ADDR_W(10)) addr_if ();

   pe_task_sequencer dut (
      .i_Clock         (clk),
      .i_Reset         (rst),
      .i_Config        (cfg),
      .i_Row_Index     (row),
      .i_Column_Index  (col),
      .i_Index_Ready   (idx_rdy),
      .o_Index_Received(idx_rcv),
      .i_Compute_Done  (cdone),
      .o_Task_Done     (tdone),
      .addr_if         (addr_if)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, wanted %0d", name, act, exp);
      end
   endtask

   task automatic push_blk(input int base, input logic [1:0] kind);
      exp_t e;
      for (int w = 0; w < 4; w++) begin
         e.a = 10'(base + w);
         e.k = kind;
         q.push_back(e);
      end
   endtask

   task automatic outputs_zero(input string name);
      check({name, "_ack"},   32'(idx_rcv), 0);
      check({name, "_valid"}, 32'(addr_if.Addr_Valid), 0);
      check({name, "_addr"},  32'(addr_if.Addr), 0);
      check({name, "_kind"},  32'(addr_if.Addr_Kind), 0);
      check({name, "_done"},  32'(tdone), 0);
   endtask

   // Called at posedge+1; returns at posedge+1 of cycle N+2
   task automatic issue(input int i, input int j, input int lam, input int gam, input int mu, input bit oor);
      cfg     = {8'h00, 8'(mu), 8'(gam), 8'(lam)};
      row     = 8'(i);
      col     = 8'(j);
      idx_rdy = 1'b1;
      @(posedge clk); #1;
      idx_rdy = 1'b0;
      check("ack_pulse", 32'(idx_rcv), 1);
      check("done_low_in_ack", 32'(tdone), 0);
      check("no_valid_in_ack", 32'(addr_if.Addr_Valid), 0);
      @(posedge clk); #1;
      check("ack_single_cycle", 32'(idx_rcv), 0);
      if (oor) begin
         check("oor_done_n2", 32'(tdone), 1);
         check("oor_no_valid", 32'(addr_if.Addr_Valid), 0);
      end else begin
         check("first_valid_n2", 32'(addr_if.Addr_Valid), (mu != 0) ? 1 : 0);
      end
   endtask

   task automatic wait_size(input string name, input int n);
      int cnt = 0;
      while (q.size() > n && cnt < 300) begin
         @(posedge clk); #1;
         cnt++;
      end
      check(name, 32'(q.size()), 32'(n));
   endtask

   task automatic drain(input string name);
      int   cnt = 0;
      logic prev;
      prev = tdone;
      while (q.size() != 0 && cnt < 300) begin
         prev = tdone;
         @(posedge clk); #1;
         cnt++;
      end
      check({name, "_drained"}, 32'(q.size()), 0);
      check({name, "_done_rise"}, 32'({prev, tdone}), 32'(2'b01));
   endtask

   // After A/B traffic: datapath idle in WAIT_PE, then C must start right after compute-done
   task automatic finish_block(input string name);
      wait_size({name, "_ab_done"}, 4);
      repeat (2) begin
         check({name, "_idle_wait_pe"}, 32'(addr_if.Addr_Valid), 0);
         @(posedge clk); #1;
      end
      cdone = 1'b1;
      @(posedge clk); #1;
      cdone = 1'b0;
      check({name, "_c_no_bubble"}, 32'(addr_if.Addr_Valid), 1);
      drain(name);
   endtask

   // Address-ready driver
   initial begin
      addr_if.Addr_Ready = 1'b1;
      forever begin
         @(posedge clk); #1;
         addr_if.Addr_Ready = toggle ? ~addr_if.Addr_Ready : 1'b1;
      end
   end

   // Monitor: compare every transfer against the queue and check stall stability
   initial begin
      exp_t e;
      stall_pend = 1'b0;
      forever begin
         @(negedge clk);
         if (rst) begin
            stall_pend = 1'b0;
         end else begin
            if (stall_pend) begin
               check("stall_valid_held", 32'(addr_if.Addr_Valid), 1);
               check("stall_addr_stable", 32'({addr_if.Addr_Kind, addr_if.Addr}),
                     32'({stall_kind, stall_addr}));
            end
            stall_pend = 1'b0;
            if (addr_if.Addr_Valid && addr_if.Addr_Ready) begin
               if (q.size() == 0) begin
                  total++;
                  bad++;
                  $display("FAIL unexpected_addr: got %0d kind %0d, wanted none", addr_if.Addr, addr_if.Addr_Kind);
               end else begin
                  e = q.pop_front();
                  check("addr", 32'(addr_if.Addr), 32'(e.a));
                  check("kind", 32'(addr_if.Addr_Kind), 32'(e.k));
               end
            end else if (addr_if.Addr_Valid) begin
               stall_pend = 1'b1;
               stall_addr = addr_if.Addr;
               stall_kind = addr_if.Addr_Kind;
            end
         end
      end
   end

   // Watchdog
   initial begin
      #200000;
      $display("FAIL timeout: got no finish, wanted finish before 200000");
      $fatal(1, "timeout");
   end

   initial begin
      total = 0; bad = 0;
      rst = 1'b1; cfg = '0; row = '0; col = '0; idx_rdy = 1'b0; cdone = 1'b0; toggle = 1'b0;
      @(posedge clk); #1;
      outputs_zero("reset");
      @(posedge clk); #1;
      rst = 1'b0;

      // Task (1,0), lambda=gamma=mu=2, ready always high
      push_blk(8, 2'b00); push_blk(256, 2'b01); push_blk(12, 2'b00); push_blk(264, 2'b01);
      push_blk(520, 2'b10);
      issue(1, 0, 2, 2, 2, 0);
      finish_block("t1");

      // Same task with ready toggling; a compute-done during fetch must be ignored
      toggle = 1'b1;
      push_blk(8, 2'b00); push_blk(256, 2'b01); push_blk(12, 2'b00); push_blk(264, 2'b01);
      push_blk(520, 2'b10);
      issue(1, 0, 2, 2, 2, 0);
      cdone = 1'b1;
      @(posedge clk); #1;
      cdone = 1'b0;
      finish_block("t2");
      toggle = 1'b0;

      // Row equal to lambda: out of range, no addresses
      issue(2, 0, 2, 2, 2, 1);
      repeat (3) @(posedge clk);
      #1;

      // mu=0: straight to WAIT_PE, C only
      push_blk(516, 2'b10);
      issue(0, 1, 2, 2, 0, 0);
      finish_block("t4");

      // Reset mid FETCH_B
      push_blk(8, 2'b00); push_blk(256, 2'b01); push_blk(12, 2'b00); push_blk(264, 2'b01);
      push_blk(520, 2'b10);
      issue(1, 0, 2, 2, 2, 0);
      wait_size("t5_mid_b", 14);
      rst = 1'b1;
      q.delete();
      @(posedge clk); #1;
      outputs_zero("midreset");
      rst = 1'b0;
      @(posedge clk); #1;
      push_blk(0, 2'b00); push_blk(260, 2'b01); push_blk(516, 2'b10);
      issue(0, 1, 2, 2, 1, 0);
      finish_block("t5");

      // Back-to-back out-of-range tasks from DONE (row boundary, then column boundary)
      check("done_before_b2b", 32'(tdone), 1);
      issue(3, 0, 2, 2, 2, 1);
      issue(0, 2, 2, 2, 2, 1);
      repeat (2) @(posedge clk);
      #1;
      check("final_queue_empty", 32'(q.size()), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
